// File: rtl/alu_cmd_issuer_if.sv
// rtl/alu_cmd_issuer_if.sv - command/response handshake bundle for alu_cmd_issuer
// Ports (signals):
//   cmd_valid/cmd_ready     command handshake
//   cmd_op, cmd_a, cmd_b    command opcode and operands
//   cmd_use_acc             take operand A from the accumulator
//   rsp_valid/rsp_ready     response handshake
//   rsp_result, rsp_err     response payload
// Modports: master = sequencer side, slave = issuer side.
interface alu_cmd_issuer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_use_acc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - issues one command at a time to a combinational ALU and returns its response
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   bus (slave)    command in (valid/ready), response out (valid/ready)
//   alu_a, alu_b   registered ALU operands
//   alu_op         registered ALU opcode
//   alu_result     combinational ALU result for alu_a/alu_b/alu_op
//   acc            running accumulator
//   rsp_count      responses consumed, wraps
module alu_cmd_issuer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_issuer_if.slave  bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] rsp_count
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] op_q;       // command opcode as received; alu_op loses clear/illegal
  logic       cmd_fire;
  logic       rsp_fire;
  logic       op_legal;
  logic       cmd_op_legal;

  assign cmd_fire     = bus.cmd_valid && bus.cmd_ready;
  assign rsp_fire     = bus.rsp_valid && bus.rsp_ready;
  assign op_legal     = (op_q <= OP_XOR);
  assign cmd_op_legal = (bus.cmd_op <= OP_XOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        // Held low while in reset so nothing is offered before release.
        bus.cmd_ready = rst_n;
        if (bus.cmd_valid && rst_n) state_next = EXEC;
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ALU drive: updated only on accept, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= OP_ADD;
      op_q   <= OP_ADD;
    end else if (cmd_fire) begin
      alu_a  <= bus.cmd_use_acc ? acc : bus.cmd_a;
      alu_b  <= bus.cmd_b;
      alu_op <= cmd_op_legal ? bus.cmd_op : OP_ADD;
      op_q   <= bus.cmd_op;
    end
  end

  // Outcome capture at the end of EXEC; response payload then holds through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_result <= '0;
      bus.rsp_err    <= 1'b0;
      acc            <= '0;
    end else if (state == EXEC) begin
      if (op_legal) begin
        bus.rsp_result <= alu_result;
        bus.rsp_err    <= 1'b0;
        acc            <= alu_result;
      end else if (op_q == OP_CLR) begin
        bus.rsp_result <= '0;
        bus.rsp_err    <= 1'b0;
        acc            <= '0;
      end else begin
        bus.rsp_result <= '0;
        bus.rsp_err    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_count <= '0;
    end else if (rsp_fire) begin
      rsp_count <= rsp_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - scoreboard bench for alu_cmd_issuer with a behavioural ALU and reference model
module tb_alu_cmd_issuer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] alu_a, alu_b, alu_result, acc;
  logic [2:0]   alu_op;
  logic [7:0]   rsp_count;

  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.WIDTH(W)) bus();

  alu_cmd_issuer #(.WIDTH(W), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .acc        (acc),
    .rsp_count  (rsp_count)
  );

  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    int result;
    int err;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   exp_count = 0;
  int   cyc = 0;
  int   ref_acc = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every response handshake is checked against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_count = 0;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_result", bus.rsp_result, e.result);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("acc", acc, e.acc);
        chk("rsp_count", rsp_count, exp_count % 256);
        exp_count++;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic ua, output int acc_cyc);
    exp_t e;
    int   aeff;
    int   r;
    int   eop;
    int   i;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_use_acc = ua;
    i = 0;
    while (!bus.cmd_ready && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    acc_cyc = 0;
    if (!bus.cmd_ready) begin
      chk("accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    aeff = ua ? ref_acc : int'(a);
    case (op)
      3'd0: r = (aeff + b) & 15;
      3'd1: r = (aeff - b) & 15;
      3'd2: r = aeff & b;
      3'd3: r = aeff | b;
      3'd4: r = aeff ^ b;
      default: r = 0;
    endcase
    eop   = (op <= 3'd4) ? int'(op) : 0;
    e.err = (op == 3'd5 || op == 3'd6) ? 1 : 0;
    if (op == 3'd7) ref_acc = 0;
    else if (e.err == 0) ref_acc = r;
    e.result = r;
    e.acc    = ref_acc;
    sb.push_back(e);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.cmd_valid = 1'b0;
    chk("alu_a", alu_a, aeff);
    chk("alu_b", alu_b, b);
    chk("alu_op", alu_op, eop);
    chk("exec_rsp_valid", bus.rsp_valid, 0);
    chk("exec_cmd_ready", bus.cmd_ready, 0);
    @(posedge clk); #1;
    chk("resp_rsp_valid", bus.rsp_valid, 1);
    n_done++;
  endtask

  initial begin
    int t, t_prev, w;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = '0;
    bus.cmd_a       = '0;
    bus.cmd_b       = '0;
    bus.cmd_use_acc = 1'b0;
    bus.rsp_ready   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_acc", acc, 0);
    chk("rst_count", rsp_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_cmd_ready", bus.cmd_ready, 1);

    // Reset while a response is pending.
    bus.rsp_ready = 1'b1;
    send(3'd0, 4'd1, 4'd1, 1'b0, t);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    send(3'd0, 4'd5, 4'd6, 1'b0, t);
    chk("pre_rst_acc", acc, 11);
    chk("pre_rst_count", rsp_count, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_acc", acc, 0);
    chk("midrst_count", rsp_count, 0);
    chk("midrst_alu_a", alu_a, 0);
    sb.delete();
    ref_acc = 0;
    n_done  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add, accumulator wrap, subtract wrap.
    bus.rsp_ready = 1'b1;
    send(3'd0, 4'd3, 4'd4, 1'b0, t);
    send(3'd0, 4'd0, 4'd12, 1'b1, t);
    send(3'd1, 4'd2, 4'd5, 1'b0, t);
    @(posedge clk); #1;

    // Backpressure with a competing command held on the input.
    bus.rsp_ready = 1'b0;
    send(3'd2, 4'hC, 4'hA, 1'b0, t);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd3;
    bus.cmd_a     = 4'd1;
    bus.cmd_b     = 4'd2;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_result", bus.rsp_result, 8);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_alu_a", alu_a, 12);
      chk("bp_alu_op", alu_op, 2);
    end
    bus.rsp_ready = 1'b1;
    send(3'd3, 4'd1, 4'd2, 1'b0, t);
    @(posedge clk); #1;

    // Illegal opcode then clear.
    send(3'd6, 4'd9, 4'd9, 1'b0, t);
    send(3'd7, 4'd9, 4'd9, 1'b0, t);
    @(posedge clk); #1;
    chk("clear_acc", acc, 0);

    // Random commands with random response stalls.
    for (int k = 0; k < 40; k++) begin
      bus.rsp_ready = 1'b0;
      send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom), t);
      w = $urandom_range(0, 3);
      repeat (w) begin
        @(posedge clk); #1;
        chk("rnd_hold_valid", bus.rsp_valid, 1);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
    end

    // Back-to-back stream: one accept every 3 cycles, counter wraps.
    bus.rsp_ready = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 256; k++) begin
      send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom), t);
      if (k > 0) chk("b2b_spacing", t - t_prev, 3);
      t_prev = t;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("final_count", rsp_count, n_done % 256);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
